// File: rtl/nco_cnt_disp_top.sv
// nco_cnt_disp_top
// Board-level seconds counter with a six-digit multiplexed 7-segment display.
// An NCO divides clk down to a one-cycle tick every NCO_NUM cycles. A modulo-60
// counter advances on each tick. A scan controller enables one digit at a time
// for SCAN_DIV cycles and shows ones/tens on the two rightmost digits.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   o_seg_enb  out  [5:0] digit enables, active-low, bit 0 = ones digit
//   o_seg_dp   out  decimal point, tied low
//   o_seg      out  [6:0] segments {a,b,c,d,e,f,g}, active-high
`timescale 1ns/1ps

module nco_cnt_disp_top #(
  parameter int unsigned NCO_NUM  = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] o_seg_enb,
  output logic       o_seg_dp,
  output logic [6:0] o_seg
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // NCO
  logic [31:0] nco_cnt_q, nco_cnt_d;
  logic        tick;

  // Seconds counter
  logic [5:0] sec_q, sec_d;
  logic [3:0] tens, ones;

  // Scan controller
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic             scan_wrap;
  logic [2:0]       idx_q, idx_d;

  // Registered display outputs
  logic [5:0] seg_enb_q, seg_enb_d;
  logic [6:0] seg_q, seg_d;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h7E;
      4'd1:    code = 7'h30;
      4'd2:    code = 7'h6D;
      4'd3:    code = 7'h79;
      4'd4:    code = 7'h33;
      4'd5:    code = 7'h5B;
      4'd6:    code = 7'h5F;
      4'd7:    code = 7'h70;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h7B;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  always_comb begin
    tick      = (nco_cnt_q == 32'(NCO_NUM - 1));
    nco_cnt_d = tick ? 32'd0 : nco_cnt_q + 32'd1;
  end

  always_comb begin
    sec_d = sec_q;
    if (tick) begin
      sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    end
    tens = 4'(sec_q / 6'd10);
    ones = 4'(sec_q % 6'd10);
  end

  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Enable and segment data come from the same index sample so they always
  // switch together on one edge.
  always_comb begin
    seg_enb_d = ~(6'b000001 << idx_q);
    case (idx_q)
      3'd0:    seg_d = seg_code(ones);
      3'd1:    seg_d = seg_code(tens);
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nco_cnt_q  <= 32'd0;
      sec_q      <= 6'd0;
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      seg_enb_q  <= 6'b111110;
      seg_q      <= 7'h7E;
    end else begin
      nco_cnt_q  <= nco_cnt_d;
      sec_q      <= sec_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_enb_q  <= seg_enb_d;
      seg_q      <= seg_d;
    end
  end

  assign o_seg_enb = seg_enb_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = 1'b0;

endmodule

// File: tb/tb_nco_cnt_disp_top.sv
`timescale 1ns/1ps

module tb_nco_cnt_disp_top;

  localparam int unsigned N = 10;
  localparam int unsigned S = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] o_seg_enb;
  logic       o_seg_dp;
  logic [6:0] o_seg;

  nco_cnt_disp_top #(
    .NCO_NUM (N),
    .SCAN_DIV(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_seg_enb(o_seg_enb),
    .o_seg_dp (o_seg_dp),
    .o_seg    (o_seg)
  );

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned c     = 0;  // rising edges since reset release

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] code_of(input int unsigned d);
    logic [6:0] tbl [10];
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    return tbl[d];
  endfunction

  // Reference: the state after edge c is a pure function of c. Outputs seen
  // after edge c reflect the count and digit index held after edge c-1.
  function automatic exp_t model(input int unsigned cyc);
    exp_t        e;
    int unsigned v, idx;
    e.dp   = 1'b0;
    e.tick = ((cyc % N) == N - 1);
    if (cyc == 0) begin
      e.enb = 6'b111110;
      e.seg = 7'h7E;
    end else begin
      v     = ((cyc - 1) / N) % 60;
      idx   = ((cyc - 1) / S) % 6;
      e.enb = 6'b111111;
      e.enb[idx] = 1'b0;
      if (idx == 0)      e.seg = code_of(v % 10);
      else if (idx == 1) e.seg = code_of(v / 10);
      else               e.seg = 7'h00;
    end
    return e;
  endfunction

  // Model process: one expectation per cycle, pushed after any reset change.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) c++;
      #4;
      if (!rst_n) c = 0;
      sb_q.push_back(model(c));
    end
  end

  // Monitor: pops and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (o_seg_enb !== e.enb) begin
          bad++;
          $display("FAIL enb t=%0t c=%0d got=%b exp=%b", $time, c, o_seg_enb, e.enb);
        end
        total++;
        if (o_seg !== e.seg) begin
          bad++;
          $display("FAIL seg t=%0t c=%0d got=%h exp=%h", $time, c, o_seg, e.seg);
        end
        total++;
        if (o_seg_dp !== e.dp) begin
          bad++;
          $display("FAIL dp t=%0t c=%0d got=%b exp=%b", $time, c, o_seg_dp, e.dp);
        end
        total++;
        if (dut.tick !== e.tick) begin
          bad++;
          $display("FAIL tick t=%0t c=%0d got=%b exp=%b", $time, c, dut.tick, e.tick);
        end
      end
    end
  end

  // Leaves the caller 3 time units after the n-th rising edge.
  task automatic wait_edges(input int unsigned n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset held for 3 cycles, then long run covering scan, 10/37 ticks, wrap.
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(700);

    // Re-sync, then reset mid-count once the count sits at 25.
    rst_n = 1'b0;
    wait_edges(1);
    rst_n = 1'b1;
    wait_edges(253);
    rst_n = 1'b0;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(150);

    // Randomised run lengths and reset pulses.
    for (int i = 0; i < 6; i++) begin
      wait_edges($urandom_range(400, 20));
      rst_n = 1'b0;
      wait_edges($urandom_range(3, 1));
      rst_n = 1'b1;
    end
    wait_edges(50);
    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
